// File: rtl/noise_acq_ctrl.sv
// Noise-window acquisition controller: after a programmable settle delay, writes N signed
// ADC samples to the noise buffer and tracks the window's running sum and peak magnitude.
module noise_acq_ctrl #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 12,
    parameter int SETTLE_W = 16
) (
    input  logic                     clkin,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [SETTLE_W-1:0]      settle_cnt,
    input  logic [ADDR_W:0]          num_samp,
    input  logic                     adc_valid,
    input  logic [DATA_W-1:0]        adc_data,
    output logic                     ram_we,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [DATA_W-1:0]        ram_wdata,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_W+ADDR_W-1:0] sum,
    output logic [DATA_W-1:0]        peak
);

    localparam int SUM_W = DATA_W + ADDR_W;
    localparam logic [ADDR_W:0]     DEPTH     = (ADDR_W+1)'(1) << ADDR_W;
    localparam logic [ADDR_W:0]     CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [SETTLE_W-1:0] SETTLE_ONE = SETTLE_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        FINISH
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [SETTLE_W-1:0]  settle_left;
    logic [ADDR_W:0]      samp_lim;
    logic [ADDR_W:0]      addr_cnt;

    logic                 go;
    logic                 take;
    logic                 last;
    logic [ADDR_W:0]      num_clamp;
    logic [DATA_W-1:0]    mag;
    logic [SUM_W-1:0]     samp_ext;

    // Windows longer than the buffer are cut to full depth so the address never wraps.
    assign num_clamp = (num_samp > DEPTH) ? DEPTH : num_samp;
    assign go        = (state == IDLE) && start && !abort;
    assign take      = (state == CAPTURE) && adc_valid && !abort;
    assign last      = take && ((addr_cnt + CNT_ONE) == samp_lim);
    // Negating the most negative code yields 2^(DATA_W-1), which is still correct read as unsigned.
    assign mag       = adc_data[DATA_W-1] ? DATA_W'(~adc_data + 1'b1) : adc_data;
    assign samp_ext  = {{ADDR_W{adc_data[DATA_W-1]}}, adc_data};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (go) begin
                    if (settle_cnt != '0)
                        state_nx = SETTLE;
                    else if (num_clamp != '0)
                        state_nx = CAPTURE;
                    else
                        state_nx = FINISH;
                end
            end
            SETTLE: begin
                if (abort)
                    state_nx = IDLE;
                else if (settle_left == SETTLE_ONE)
                    state_nx = (samp_lim == '0) ? FINISH : CAPTURE;
            end
            CAPTURE: begin
                if (abort)
                    state_nx = IDLE;
                else if (last)
                    state_nx = FINISH;
            end
            FINISH: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            state       <= IDLE;
            settle_left <= '0;
            samp_lim    <= '0;
            addr_cnt    <= '0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sum         <= '0;
            peak        <= '0;
        end else begin
            state  <= state_nx;
            busy   <= (state_nx != IDLE);
            done   <= (state_nx == FINISH);
            ram_we <= take;

            if (go) begin
                settle_left <= settle_cnt;
                samp_lim    <= num_clamp;
                addr_cnt    <= '0;
                sum         <= '0;
                peak        <= '0;
            end

            if (state == SETTLE)
                settle_left <= settle_left - SETTLE_ONE;

            if (take) begin
                ram_addr  <= addr_cnt[ADDR_W-1:0];
                ram_wdata <= adc_data;
                sum       <= sum + samp_ext;
                if (mag > peak)
                    peak <= mag;
                addr_cnt  <= addr_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_noise_acq_ctrl.sv
// Bench for noise_acq_ctrl: window-level reference model checked every cycle, directed
// scenarios with literal expectations, then a randomized soak.
module tb_noise_acq_ctrl;

    localparam int AW = 12;
    localparam int DW = 12;
    localparam int SW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             start;
    logic             abort;
    logic [SW-1:0]    settle_cnt;
    logic [AW:0]      num_samp;
    logic             adc_valid;
    logic [DW-1:0]    adc_data;
    logic             ram_we;
    logic [AW-1:0]    ram_addr;
    logic [DW-1:0]    ram_wdata;
    logic             busy;
    logic             done;
    logic [DW+AW-1:0] sum;
    logic [DW-1:0]    peak;

    noise_acq_ctrl #(.ADDR_W(AW), .DATA_W(DW), .SETTLE_W(SW)) dut (
        .clkin(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .settle_cnt(settle_cnt), .num_samp(num_samp),
        .adc_valid(adc_valid), .adc_data(adc_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .busy(busy), .done(done), .sum(sum), .peak(peak)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a window is "active" from start until it ends; it first burns
    // m_wait cycles, then takes samples until m_left reaches zero, then spends one ending cycle.
    bit               started = 1'b0;
    bit               m_active = 1'b0;
    bit               m_ending = 1'b0;
    int               m_wait = 0;
    int               m_left = 0;
    int               m_addr = 0;
    logic             e_we = 1'b0, e_busy = 1'b0, e_done = 1'b0;
    logic [AW-1:0]    e_addr = '0;
    logic [DW-1:0]    e_wdata = '0;
    logic [DW+AW-1:0] e_sum = '0;
    logic [DW-1:0]    e_peak = '0;

    always @(posedge clk) begin
        bit act, endg;
        int wt, lf, ad, d, a;
        logic we, dn;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd, pk;
        logic [DW+AW-1:0] sm;
        act = m_active; endg = m_ending; wt = m_wait; lf = m_left; ad = m_addr;
        we = 1'b0; dn = 1'b0; addr = e_addr; wd = e_wdata; pk = e_peak; sm = e_sum;
        if (!rst_n) begin
            act = 0; endg = 0; wt = 0; lf = 0; ad = 0;
            addr = '0; wd = '0; pk = '0; sm = '0;
        end else if (!act) begin
            if (start && !abort) begin
                act = 1;
                wt  = int'(settle_cnt);
                lf  = (int'(num_samp) > 4096) ? 4096 : int'(num_samp);
                ad  = 0; sm = '0; pk = '0;
                if (wt == 0 && lf == 0) begin endg = 1; dn = 1; end
            end
        end else if (abort || endg) begin
            act = 0; endg = 0;
        end else if (wt > 0) begin
            wt--;
            if (wt == 0 && lf == 0) begin endg = 1; dn = 1; end
        end else if (adc_valid) begin
            we   = 1'b1;
            addr = AW'(ad);
            wd   = adc_data;
            d    = int'($signed(adc_data));
            a    = (d < 0) ? -d : d;
            sm   = sm + (DW+AW)'(d);
            if (a > int'(pk)) pk = DW'(a);
            ad++;
            lf--;
            if (lf == 0) begin endg = 1; dn = 1; end
        end
        m_active <= act; m_ending <= endg; m_wait <= wt; m_left <= lf; m_addr <= ad;
        e_we <= we; e_done <= dn; e_busy <= act;
        e_addr <= addr; e_wdata <= wd; e_sum <= sm; e_peak <= pk;
        started <= 1'b1;
    end

    int            done_cnt = 0;
    int            wr_cnt = 0;
    logic [AW-1:0] last_addr = '0;
    logic [AW-1:0] done_addr = '0;
    logic          done_we = 1'b0;

    always @(negedge clk) begin
        if (started) begin
            chk("ram_we",    64'(ram_we),    64'(e_we));
            chk("busy",      64'(busy),      64'(e_busy));
            chk("done",      64'(done),      64'(e_done));
            chk("ram_addr",  64'(ram_addr),  64'(e_addr));
            chk("ram_wdata", 64'(ram_wdata), 64'(e_wdata));
            chk("sum",       64'(sum),       64'(e_sum));
            chk("peak",      64'(peak),      64'(e_peak));
            if (done === 1'b1) begin
                done_cnt++;
                done_we   = ram_we;
                done_addr = ram_addr;
            end
            if (ram_we === 1'b1) begin
                wr_cnt++;
                last_addr = ram_addr;
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input int s, input int n);
        settle_cnt = SW'(s);
        num_samp   = (AW+1)'(n);
        start      = 1'b1;
        cyc();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string nm);
        bit seen = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
            @(posedge clk);
            #1;
            if (seen) break;
        end
        chk({nm, "_done_seen"}, 64'(seen), 64'd1);
    endtask

    int bd, bw;

    initial begin
        int vals[4];
        bit pat[5];
        vals = '{5, -3, 7, -1};
        pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; adc_valid = 1'b0;
        adc_data = '0; settle_cnt = '0; num_samp = '0;
        cyc(2);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_sum",  64'(sum),  64'd0);
        chk("reset_addr", 64'(ram_addr), 64'd0);
        rst_n = 1'b1;
        cyc(2);

        // basic window
        bd = done_cnt; bw = wr_cnt;
        pulse_start(3, 4);
        cyc(3);
        for (int i = 0; i < 4; i++) begin
            adc_valid = 1'b1;
            adc_data  = DW'(vals[i]);
            cyc();
        end
        adc_valid = 1'b0;
        cyc(2);
        chk("basic_sum",       64'(sum),           64'd8);
        chk("basic_peak",      64'(peak),          64'd7);
        chk("basic_done_cnt",  64'(done_cnt - bd), 64'd1);
        chk("basic_writes",    64'(wr_cnt - bw),   64'd4);
        chk("basic_done_we",   64'(done_we),       64'd1);
        chk("basic_done_addr", 64'(done_addr),     64'd3);

        // zero settle, two samples
        bw = wr_cnt;
        adc_valid = 1'b1; adc_data = DW'(100);
        pulse_start(0, 2);
        cyc();
        adc_data = DW'(200);
        @(negedge clk);
        chk("zs_first_we", 64'(ram_we), 64'd1);
        cyc();
        adc_valid = 1'b0;
        cyc(2);
        chk("zs_writes", 64'(wr_cnt - bw), 64'd2);
        chk("zs_sum",    64'(sum),         64'd300);

        // zero settle, zero count
        bw = wr_cnt;
        pulse_start(0, 0);
        @(negedge clk);
        chk("zz_done", 64'(done), 64'd1);
        cyc(2);
        chk("zz_sum",    64'(sum),         64'd0);
        chk("zz_peak",   64'(peak),        64'd0);
        chk("zz_writes", 64'(wr_cnt - bw), 64'd0);

        // full scale, full depth
        bw = wr_cnt;
        adc_valid = 1'b1; adc_data = 12'h800;
        pulse_start(0, 4096);
        wait_done(4200, "full");
        adc_valid = 1'b0;
        cyc();
        chk("full_writes", 64'(wr_cnt - bw), 64'd4096);
        chk("full_last",   64'(last_addr),   64'd4095);
        chk("full_sum",    64'(sum),         64'h800000);
        chk("full_peak",   64'(peak),        64'd2048);

        // oversize count clamps to depth
        bw = wr_cnt;
        adc_valid = 1'b1; adc_data = DW'(1);
        pulse_start(0, 5000);
        wait_done(5200, "clamp");
        adc_valid = 1'b0;
        cyc();
        chk("clamp_writes", 64'(wr_cnt - bw), 64'd4096);
        chk("clamp_sum",    64'(sum),         64'd4096);

        // gapped strobe with a stray start mid-capture
        bd = done_cnt; bw = wr_cnt;
        pulse_start(0, 3);
        for (int i = 0; i < 5; i++) begin
            adc_valid = pat[i];
            adc_data  = DW'(11 * (i + 1));
            start     = (i == 1);
            cyc();
        end
        start = 1'b0; adc_valid = 1'b0;
        cyc(3);
        chk("gap_writes",   64'(wr_cnt - bw),   64'd3);
        chk("gap_done_cnt", 64'(done_cnt - bd), 64'd1);
        chk("gap_last",     64'(last_addr),     64'd2);
        chk("gap_sum",      64'(sum),           64'd110);

        // abort after two of four samples
        bd = done_cnt; bw = wr_cnt;
        pulse_start(1, 4);
        cyc();
        adc_valid = 1'b1; adc_data = DW'(10);  cyc();
        adc_data = DW'(-20); cyc();
        abort = 1'b1; adc_data = DW'(99); cyc();
        abort = 1'b0; adc_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        cyc(2);
        chk("abort_done_cnt", 64'(done_cnt - bd), 64'd0);
        chk("abort_writes",   64'(wr_cnt - bw),   64'd2);
        chk("abort_sum",      64'(sum),           64'hFFFFF6);
        chk("abort_peak",     64'(peak),          64'd20);
        adc_valid = 1'b1; adc_data = DW'(3);
        pulse_start(0, 2);
        wait_done(10, "post_abort");
        adc_valid = 1'b0;
        cyc();
        chk("post_abort_sum",  64'(sum),  64'd6);
        chk("post_abort_peak", 64'(peak), 64'd3);

        // reset during capture
        bd = done_cnt;
        adc_valid = 1'b1; adc_data = DW'(7);
        pulse_start(0, 4);
        cyc(2);
        rst_n = 1'b0;
        cyc();
        @(negedge clk);
        chk("rst_busy", 64'(busy),     64'd0);
        chk("rst_we",   64'(ram_we),   64'd0);
        chk("rst_addr", 64'(ram_addr), 64'd0);
        chk("rst_sum",  64'(sum),      64'd0);
        chk("rst_peak", 64'(peak),     64'd0);
        rst_n = 1'b1; adc_valid = 1'b0;
        cyc(3);
        chk("rst_done_cnt", 64'(done_cnt - bd), 64'd0);

        // randomized soak
        for (int c = 0; c < 6000; c++) begin
            start      = ($urandom_range(0, 9) == 0);
            abort      = ($urandom_range(0, 49) == 0);
            adc_valid  = ($urandom_range(0, 9) < 7);
            adc_data   = ($urandom_range(0, 15) == 0) ? 12'h800 : DW'($urandom);
            settle_cnt = SW'($urandom_range(0, 4));
            num_samp   = ($urandom_range(0, 29) == 0) ? (AW+1)'($urandom_range(4000, 8191))
                                                      : (AW+1)'($urandom_range(0, 12));
            rst_n      = ($urandom_range(0, 299) != 0);
            cyc();
        end
        rst_n = 1'b1; start = 1'b0; abort = 1'b0; adc_valid = 1'b0;
        cyc(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/noise_acq_ctrl.md
Name: noise_acq_ctrl

Overview:
- Noise-window acquisition controller. Sits directly downstream of the 12-bit noise address counter stage and replaces free-running addressing with a controlled capture window.
- On a start command it waits a programmable settle time, then writes N signed ADC samples into the 4096-word noise buffer RAM at sequential addresses.
- It also accumulates the running sum and peak magnitude of the window for the noise-estimate logic.
- It pulses done when the window is complete.

Parameters:
- ADDR_W, 12, buffer address width; depth = 2^ADDR_W.
- DATA_W, 12, ADC sample width, two's complement.
- SETTLE_W, 16, settle counter width.

Ports:
- clkin  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle start request.
- abort  input  1  cancel the current window.
- settle_cnt  input  SETTLE_W  settle cycles before capture; latched at start.
- num_samp  input  ADDR_W+1  samples per window; latched at start.
- adc_valid  input  1  sample strobe.
- adc_data  input  DATA_W  signed sample.
- ram_we  output  1  buffer write enable.
- ram_addr  output  ADDR_W  buffer write address.
- ram_wdata  output  DATA_W  buffer write data.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle completion pulse.
- sum  output  DATA_W+ADDR_W  signed window sum.
- peak  output  DATA_W  unsigned maximum |sample|.

Behaviour:
- Clock and reset: one clock, clkin. rst_n is synchronous and active-low.
- Reset values: all outputs 0; state IDLE; internal counters 0.
- States: IDLE, SETTLE, CAPTURE, FINISH. All outputs are registered.
- IDLE:
  - When start=1 and abort=0:
    - latch settle_cnt and num_samp;
    - clamp num_samp > 2^ADDR_W to 2^ADDR_W;
    - clear sum, peak and the address counter.
  - Next state: SETTLE if settle_cnt != 0; else CAPTURE if num_samp != 0; else FINISH.
- SETTLE:
  - Exactly settle_cnt cycles in this state, then CAPTURE, or FINISH if num_samp = 0.
  - adc_valid is ignored.
- CAPTURE:
  - A sample is accepted in every cycle with adc_valid=1.
  - At the edge ending an accepting cycle:
    - ram_we <= 1;
    - ram_addr <= address counter;
    - ram_wdata <= adc_data;
    - sum <= sum + sign-extended adc_data;
    - peak <= max(peak, |adc_data|);
    - address counter increments.
  - Otherwise ram_we <= 0.
  - Write latency is 1 cycle from sample to ram_we.
  - |-2^(DATA_W-1)| = 2^(DATA_W-1), which fits unsigned DATA_W.
  - sum is DATA_W+ADDR_W bits and cannot overflow at maximum depth.
  - Gaps in adc_valid stall the capture without limit; there is no timeout.
  - At the edge accepting the num_samp-th sample, state goes to FINISH.
- FINISH:
  - Lasts one cycle.
  - done=1 in this cycle, together with the final ram_we write; sum and peak are final.
  - Next state: IDLE.
- Hold: sum and peak hold their values until the next accepted start.
- Address range: the address never exceeds num_samp-1, so no wrap occurs. A window of 2^ADDR_W samples ends with the last write at address 2^ADDR_W-1.
- start while busy: ignored, no effect.
- abort=1 in SETTLE, CAPTURE or FINISH:
  - next state is IDLE;
  - ram_we <= 0; any sample in that cycle is discarded;
  - no done pulse;
  - sum and peak keep their partial values.
- abort=1 in IDLE: suppresses start in the same cycle.
- rst_n=0 mid-window: all registers go to reset values at the next edge; no done pulse.
- Boundaries: busy falls in the cycle after FINISH. A new start is accepted in the first IDLE cycle after FINISH.

Test Plan:
- Basic window:
  - Stimulus: settle_cnt=3, num_samp=4, start, then adc_valid continuous with data 5, -3, 7, -1.
  - Required: busy for 3 SETTLE cycles; writes at addr 0..3 with those values; sum=8, peak=7; done once, in the cycle of the addr-3 write.
- Zero settle and zero count:
  - settle_cnt=0, num_samp=2: capture starts the cycle after start.
  - settle_cnt=0, num_samp=0: done one cycle after start, sum=0, peak=0, no ram_we.
- Full-scale and full depth:
  - Stimulus: num_samp=4096, all samples -2048.
  - Required: last write at addr 4095; sum=-8388608 (0x800000); peak=2048; no addr wrap.
  - Separately: num_samp=5000 clamps to 4096 writes.
- Gapped strobe and start while busy:
  - Stimulus: adc_valid 1-0-0-1-1 with num_samp=3; a second start pulse during CAPTURE.
  - Required: exactly 3 writes at addr 0, 1, 2; the second start is ignored; a single done.
- Abort:
  - Stimulus: abort after 2 of 4 samples.
  - Required: IDLE next cycle, no done; sum and peak reflect the 2 samples; a subsequent start clears them and runs normally.
- Reset mid-capture:
  - Stimulus: rst_n=0 for one cycle during CAPTURE.
  - Required: all outputs 0 after the edge; state IDLE; no done.
